// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard receiver: pin sync/filter, frame deframer, E0/F0 prefix folding, event FIFO
module ps2_scancode_rx #(
    parameter int FILT_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2c,
    input  logic                          ps2d,
    input  logic                          rd_en,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------------------------------------------------------
    // Input path: index 0 is the clock pin, index 1 the data pin
    // ---------------------------------------------------------------
    logic [1:0]    pin_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [FW-1:0] fcnt [2];
    logic          filt_c_q;
    logic          fall;
    logic          dbit;

    assign pin_raw = {ps2d, ps2c};

    // Filtered value only flips once FILT_LEN consecutive samples disagree with it
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            filt     <= 2'b11;
            filt_c_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1    <= pin_raw;
            sync2    <= sync1;
            filt_c_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign fall = filt_c_q & ~filt[0];
    assign dbit = filt[1];

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    state_t        state;
    state_t        state_n;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          byte_ok;
    logic          perr;
    logic          ferr;

    assign timeout = (state != S_IDLE) && !fall && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE || fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (fall) begin
                case (state)
                    S_IDLE:   bitcnt <= '0;
                    S_DATA: begin
                        shreg  <= {dbit, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                    end
                    S_PARITY: par_bit <= dbit;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (fall && !dbit) state_n = S_DATA;
            S_DATA:   if (fall && bitcnt == 3'd7) state_n = S_PARITY;
            S_PARITY: if (fall) state_n = S_STOP;
            S_STOP:   if (fall) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (timeout) state_n = S_IDLE;
    end

    // A bad stop bit outranks a bad parity bit
    always_comb begin
        byte_ok = 1'b0;
        perr    = 1'b0;
        ferr    = 1'b0;
        if (state == S_STOP && fall) begin
            if (!dbit) begin
                ferr = 1'b1;
            end else if (!(^{shreg, par_bit})) begin
                perr = 1'b1;
            end else begin
                byte_ok = 1'b1;
            end
        end
        if (timeout) ferr = 1'b1;
    end

    logic       byte_stb;
    logic [7:0] byte_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_stb   <= 1'b0;
            byte_q     <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_stb   <= byte_ok;
            parity_err <= perr;
            frame_err  <= ferr;
            if (byte_ok) byte_q <= shreg;
        end
    end

    // ---------------------------------------------------------------
    // Prefix decoder
    // ---------------------------------------------------------------
    logic       ext_pend;
    logic       brk_pend;
    logic       is_pfx;
    logic       push;
    logic [9:0] push_data;

    assign is_pfx    = (byte_q == 8'hE0) || (byte_q == 8'hF0);
    assign push      = byte_stb && !is_pfx;
    assign push_data = {ext_pend, brk_pend, byte_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (parity_err || frame_err) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_stb) begin
            if (byte_q == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Show-ahead event FIFO
    // ---------------------------------------------------------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          wr_ok;
    logic [9:0]    head;

    assign full  = (count == CNT_FULL);
    assign pop   = rd_en && ev_valid;
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head fields read as zero while empty so nothing stale leaks out
    assign head     = mem[rd_ptr];
    assign ev_valid = (count != '0);
    assign ev_code  = ev_valid ? head[7:0] : 8'h00;
    assign ev_break = ev_valid ? head[8] : 1'b0;
    assign ev_ext   = ev_valid ? head[9] : 1'b0;
    assign ev_count = count;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - directed and randomized bench for ps2_scancode_rx against a queue-based model
module tb_ps2_scancode_rx;
    localparam int FILT  = 4;
    localparam int TO    = 200;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2c;
    logic       ps2d;
    logic       rd_en;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [3:0] ev_count;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;

    ps2_scancode_rx #(.FILT_LEN(FILT), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d), .rd_en(rd_en),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
        .ev_count(ev_count), .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int perr_cnt    = 0;
    int ferr_cnt    = 0;
    int exp_perr    = 0;
    int exp_ferr    = 0;
    int half        = 20;

    logic [9:0] mq[$];
    bit         m_ext;
    bit         m_brk;
    bit         m_ovf;

    // Error pulses are counted as high cycles, so a stretched pulse shows up as an extra count
    always @(negedge clk) begin
        if (parity_err) perr_cnt++;
        if (frame_err)  ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
            else                   m_ovf = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic void model_err();
        m_ext = 1'b0;
        m_brk = 1'b0;
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2d = frame[i];
            wait_clks(half);
            ps2c = 1'b0;
            wait_clks(half);
            ps2c = 1'b1;
            if (i == glitch_bit) begin
                wait_clks(4);
                ps2c = 1'b0;
                wait_clks(FILT - 1);
                ps2c = 1'b1;
            end
        end
        ps2d = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_bits(make_frame(b, 1'b0, 1'b1), 11, -1);
        model_byte(b);
    endtask

    task automatic check_state(input string tag);
        wait_clks(10);
        check({tag, "_valid"}, ev_valid, (mq.size() != 0));
        check({tag, "_count"}, ev_count, mq.size());
        check({tag, "_ovf"}, overflow, m_ovf);
        check({tag, "_perr"}, perr_cnt, exp_perr);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        if (mq.size() != 0) begin
            check({tag, "_code"}, ev_code, mq[0][7:0]);
            check({tag, "_brk"}, ev_break, mq[0][8]);
            check({tag, "_ext"}, ev_ext, mq[0][9]);
        end
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        mq.delete();
        model_err();
        m_ovf = 1'b0;
    endtask

    initial begin
        logic [7:0] code;
        rst   = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rd_en = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(2);
        check("rst_valid", ev_valid, 1'b0);
        check("rst_count", ev_count, 4'd0);
        check("rst_code", ev_code, 8'h00);
        check("rst_ovf", overflow, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_ferr", frame_err, 1'b0);

        // Single frame 0x1C; event cannot appear before the filter has even seen the stop fall
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 10, -1);
        ps2d = 1'b1;
        wait_clks(half);
        ps2c = 1'b0;
        wait_clks(FILT);
        check("t1_early", ev_valid, 1'b0);
        wait_clks(half - FILT);
        ps2c = 1'b1;
        model_byte(8'h1C);
        check_state("t1");
        pop_one();
        check_state("t1_pop");
        pop_one();
        check_state("t1_empty_pop");

        // Prefix folding
        send_good(8'hF0);
        send_good(8'h1C);
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        check_state("t2");
        pop_one();
        check_state("t2_pop");
        pop_one();

        // Parity error clears the pending F0
        send_good(8'hF0);
        send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11, -1);
        exp_perr++;
        model_err();
        check_state("t3_perr");
        send_good(8'h1D);
        check_state("t3_next");
        pop_one();

        // Bad stop bit, alone and together with bad parity
        send_bits(make_frame(8'h33, 1'b0, 1'b0), 11, -1);
        exp_ferr++;
        model_err();
        check_state("stop_err");
        send_bits(make_frame(8'h33, 1'b1, 1'b0), 11, -1);
        exp_ferr++;
        model_err();
        check_state("stop_par_err");

        // Timeout after 5 data bits also clears the pending E0
        send_good(8'hE0);
        send_bits(make_frame(8'h55, 1'b0, 1'b1), 6, -1);
        wait_clks(TO + 10);
        exp_ferr++;
        model_err();
        check_state("t4_to");
        send_good(8'h2A);
        check_state("t4_next");
        pop_one();

        // Overflow
        for (int i = 1; i <= 9; i++) send_good(8'(i));
        check_state("t5_full");
        for (int i = 1; i <= 8; i++) begin
            check("t5_drain", ev_code, 32'(i));
            pop_one();
        end
        check_state("t5_empty");

        // Glitch mid-frame, then reset mid-frame
        send_bits(make_frame(8'h5A, 1'b0, 1'b1), 11, 3);
        model_byte(8'h5A);
        check_state("t6_glitch");
        send_bits(make_frame(8'h33, 1'b0, 1'b1), 5, -1);
        apply_reset();
        check_state("t6_rst");
        send_good(8'h44);
        check_state("t6_next");
        pop_one();

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            half = $urandom_range(12, 20);
            do code = 8'($urandom_range(0, 255)); while (code == 8'hE0 || code == 8'hF0);
            if ($urandom_range(0, 1) == 1) send_good(8'hE0);
            if ($urandom_range(0, 1) == 1) send_good(8'hF0);
            send_good(code);
            check_state("rnd");
            if ($urandom_range(0, 2) == 0) begin
                pop_one();
                check_state("rnd_pop");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
